// File: rtl/scale_cache_pp_if.sv
// scale_cache_pp_if: write-stream and random-read bus of the ping-pong scaled-image cache
interface scale_cache_pp_if #(
  parameter int ROW_SIZE = 320,
  parameter int COL_SIZE = 240,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 1
);
  localparam int ROW_WIDTH = $clog2(ROW_SIZE);
  localparam int COL_WIDTH = $clog2(COL_SIZE);
  localparam int WORD_SIZE = DEPTH * CHANNELS;
  logic                 wr_valid;
  logic                 wr_sof;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 wr_ready;
  logic                 wr_frame_done;
  logic                 rd_frame_avail;
  logic                 rd_req;
  logic [COL_WIDTH-1:0] rd_row;
  logic [ROW_WIDTH-1:0] rd_col;
  logic                 rd_release;
  logic                 rd_valid;
  logic [WORD_SIZE-1:0] rd_data;
  logic                 rd_err;
  modport master (
    output wr_valid, wr_sof, wr_data, rd_req, rd_row, rd_col, rd_release,
    input  wr_ready, wr_frame_done, rd_frame_avail, rd_valid, rd_data, rd_err
  );
  modport slave (
    input  wr_valid, wr_sof, wr_data, rd_req, rd_row, rd_col, rd_release,
    output wr_ready, wr_frame_done, rd_frame_avail, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/scale_cache_pp.sv
// scale_cache_pp: ping-pong multi-channel image cache, raster writes into one bank, random 2-cycle reads from the other
module scale_cache_pp #(
  parameter int ROW_SIZE = 320,
  parameter int COL_SIZE = 240,
  parameter int DEPTH    = 8,
  parameter int CHANNELS = 1
) (
  input logic             clk,
  input logic             rst_n,
  scale_cache_pp_if.slave bus
);
  localparam int ROW_WIDTH  = $clog2(ROW_SIZE);
  localparam int COL_WIDTH  = $clog2(COL_SIZE);
  localparam int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE);
  localparam int WORD_SIZE  = DEPTH * CHANNELS;
  localparam int N          = ROW_SIZE * COL_SIZE;
  logic [WORD_SIZE-1:0]  r_mem [2][N];
  logic                  r_wr_sel;
  logic                  r_rd_sel;
  logic [1:0]            r_full;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ROW_WIDTH-1:0]  r_col;
  logic [COL_WIDTH-1:0]  r_row;
  logic                  r_frame_done;
  logic                  r_rd1_v;
  logic                  r_rd1_err;
  logic                  r_rd1_bank;
  logic [ADDR_WIDTH-1:0] r_rd1_addr;
  logic                  r_rd_valid;
  logic                  r_rd_err;
  logic [WORD_SIZE-1:0]  r_rd_data;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_col_wrap;
  logic                  w_release;
  logic                  w_rd_err;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ROW_WIDTH-1:0]  w_col;
  logic [COL_WIDTH-1:0]  w_row;
  logic [1:0]            w_full;
  // A start-of-frame pixel overrides the running position so the bank restarts at (0,0)
  always_comb begin
    w_accept   = bus.wr_valid && !r_full[r_wr_sel];
    w_wr_addr  = bus.wr_sof ? '0 : r_wr_addr;
    w_col      = bus.wr_sof ? '0 : r_col;
    w_row      = bus.wr_sof ? '0 : r_row;
    w_col_wrap = 32'(w_col) == ROW_SIZE - 1;
    w_last     = w_col_wrap && 32'(w_row) == COL_SIZE - 1;
    w_release  = bus.rd_release && r_full[r_rd_sel];
    w_rd_err   = 32'(bus.rd_row) >= COL_SIZE || 32'(bus.rd_col) >= ROW_SIZE || !r_full[r_rd_sel];
    w_rd_addr  = ADDR_WIDTH'(32'(bus.rd_row) * ROW_SIZE + 32'(bus.rd_col));
    w_full     = r_full;
    if (w_accept && w_last) w_full[r_wr_sel] = 1'b1;
    if (w_release) w_full[r_rd_sel] = 1'b0;
  end
  always_ff @(posedge clk)
    if (w_accept) r_mem[r_wr_sel][w_wr_addr] <= bus.wr_data;
  // Writer only completes a non-full bank and reader only releases a full one, so both full-bit updates may land together
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_sel     <= 1'b0;
      r_rd_sel     <= 1'b0;
      r_full       <= '0;
      r_wr_addr    <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
      r_rd1_v      <= 1'b0;
      r_rd1_err    <= 1'b0;
      r_rd1_bank   <= 1'b0;
      r_rd1_addr   <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_err     <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_full       <= w_full;
      r_frame_done <= w_accept && w_last;
      if (w_accept && w_last) r_wr_sel <= !r_wr_sel;
      if (w_release) r_rd_sel <= !r_rd_sel;
      if (w_accept) begin
        r_wr_addr <= w_last ? '0 : w_wr_addr + 1'b1;
        r_col     <= w_col_wrap ? '0 : w_col + 1'b1;
        r_row     <= w_last ? '0 : w_col_wrap ? w_row + 1'b1 : w_row;
      end
      r_rd1_v    <= bus.rd_req;
      r_rd1_err  <= w_rd_err;
      r_rd1_bank <= r_rd_sel;
      r_rd1_addr <= w_rd_addr;
      r_rd_valid <= r_rd1_v;
      r_rd_err   <= r_rd1_v && r_rd1_err;
      r_rd_data  <= r_rd1_v && !r_rd1_err ? r_mem[r_rd1_bank][r_rd1_addr] : '0;
    end
  assign bus.wr_ready       = !r_full[r_wr_sel];
  assign bus.rd_frame_avail = r_full[r_rd_sel];
  assign bus.wr_frame_done  = r_frame_done;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.rd_err         = r_rd_err;
  assign bus.rd_data        = r_rd_data;
endmodule

// File: tb/tb_scale_cache_pp.sv
// tb_scale_cache_pp: directed and randomized checks of the ping-pong cache against a frame-level model
module tb_scale_cache_pp;
  localparam int N = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  scale_cache_pp_if #(.ROW_SIZE(4), .COL_SIZE(3), .DEPTH(8), .CHANNELS(2)) bus ();
  scale_cache_pp #(.ROW_SIZE(4), .COL_SIZE(3), .DEPTH(8), .CHANNELS(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] m_mem [2][N];
  bit m_full [2];
  bit m_wsel, m_rsel;
  int m_pos;
  bit p1_v, p1_err;
  logic [15:0] p1_data;
  logic [20:0] exp_v;
  wire [20:0] obs = {bus.wr_ready, bus.rd_frame_avail, bus.wr_frame_done, bus.rd_valid,
                     bus.rd_valid ? {bus.rd_err, bus.rd_data} : 17'h0};
  task automatic drive(input bit v, input bit sof, input logic [15:0] d, input bit req,
                       input logic [1:0] row, input logic [1:0] col, input bit rel);
    bus.wr_valid = v;
    bus.wr_sof = sof;
    bus.wr_data = d;
    bus.rd_req = req;
    bus.rd_row = row;
    bus.rd_col = col;
    bus.rd_release = rel;
  endtask
  task automatic model_clear();
    m_full = '{0, 0};
    m_wsel = 0;
    m_rsel = 0;
    m_pos = 0;
    p1_v = 0;
    p1_err = 0;
    p1_data = '0;
    exp_v = {1'b1, 20'h0};
  endtask
  // Frame-level model: a pixel index per frame, a full flag per bank, responses delayed one step
  task automatic step();
    bit acc, rel, err, req, last;
    int idx, a;
    logic [15:0] d;
    acc = bus.wr_valid && !m_full[m_wsel];
    rel = bus.rd_release && m_full[m_rsel];
    req = bus.rd_req;
    err = bus.rd_row >= 2'd3 || !m_full[m_rsel];
    a = int'(bus.rd_row) * 4 + int'(bus.rd_col);
    d = '0;
    if (!err) d = m_mem[m_rsel][a];
    last = 0;
    if (acc) begin
      idx = bus.wr_sof ? 0 : m_pos;
      m_mem[m_wsel][idx] = bus.wr_data;
      m_pos = idx + 1;
      if (m_pos == N) begin
        last = 1;
        m_full[m_wsel] = 1;
        m_wsel = !m_wsel;
        m_pos = 0;
      end
    end
    if (rel) begin
      m_full[m_rsel] = 0;
      m_rsel = !m_rsel;
    end
    @(posedge clk);
    #1;
    exp_v = {!m_full[m_wsel], m_full[m_rsel], last, p1_v, p1_v ? {p1_err, p1_data} : 17'h0};
    p1_v = req;
    p1_err = err;
    p1_data = d;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_clear();
  endtask
  task automatic test_reset();
    do_reset();
    vectors++;
    if (obs !== {1'b1, 20'h0}) begin
      miscompares++;
      $display("FAIL reset_state got %h expected %h", obs, {1'b1, 20'h0});
    end
  endtask
  task automatic test_single_frame();
    int dones = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, i == 0, {8'(i), ~8'(i)}, 0, 0, 0, 0);
      step();
      dones += int'(bus.wr_frame_done);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL frame1_px%0d got %h expected %h", i, obs, exp_v);
      end
    end
    drive(0, 0, 0, 1, 2, 3, 0);
    step();
    dones += int'(bus.wr_frame_done);
    vectors++;
    if (dones !== 1 || bus.rd_frame_avail !== 1'b1) begin
      miscompares++;
      $display("FAIL frame1_done got dones=%0d avail=%b expected dones=1 avail=1", dones, bus.rd_frame_avail);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    vectors++;
    if ({bus.rd_valid, bus.rd_err, bus.rd_data} !== {2'b10, 16'h0BF4}) begin
      miscompares++;
      $display("FAIL read_2_3 got v=%b e=%b d=%h expected v=1 e=0 d=0bf4", bus.rd_valid, bus.rd_err, bus.rd_data);
    end
  endtask
  task automatic test_backpressure();
    for (int i = 12; i < 24; i++) begin
      drive(1, 0, {8'(i), ~8'(i)}, 0, 0, 0, 0);
      step();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL frame2_px%0d got %h expected %h", i, obs, exp_v);
      end
    end
    vectors++;
    if (bus.wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL both_full_ready got %b expected 0", bus.wr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 16'hDEAD, 0, 0, 0, 0);
      step();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL stalled_write%0d got %h expected %h", i, obs, exp_v);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    vectors++;
    if (bus.wr_ready !== 1'b1 || obs !== exp_v) begin
      miscompares++;
      $display("FAIL release_ready got %h expected %h", obs, exp_v);
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    vectors++;
    if ({bus.rd_valid, bus.rd_err, bus.rd_data} !== {2'b10, 16'h0CF3}) begin
      miscompares++;
      $display("FAIL frame2_read_0_0 got v=%b e=%b d=%h expected v=1 e=0 d=0cf3", bus.rd_valid, bus.rd_err, bus.rd_data);
    end
  endtask
  task automatic test_errors();
    drive(0, 0, 0, 1, 3, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    vectors++;
    if ({bus.rd_valid, bus.rd_err, bus.rd_data} !== {2'b11, 16'h0} || obs !== exp_v) begin
      miscompares++;
      $display("FAIL row_out_of_range got %h expected %h", obs, exp_v);
    end
    do_reset();
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    vectors++;
    if ({bus.rd_valid, bus.rd_err, bus.rd_data} !== {2'b11, 16'h0}) begin
      miscompares++;
      $display("FAIL read_unavailable got v=%b e=%b d=%h expected v=1 e=1 d=0000", bus.rd_valid, bus.rd_err, bus.rd_data);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    vectors++;
    if (obs !== {1'b1, 20'h0} || obs !== exp_v) begin
      miscompares++;
      $display("FAIL idle_release got %h expected %h", obs, {1'b1, 20'h0});
    end
  endtask
  task automatic test_resync();
    int done_at = -1;
    for (int i = 0; i < 17; i++) begin
      drive(1, i == 0 || i == 5, i == 5 ? 16'hAA55 : 16'($urandom), 0, 0, 0, 0);
      step();
      if (bus.wr_frame_done === 1'b1) done_at = i;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL resync_px%0d got %h expected %h", i, obs, exp_v);
      end
    end
    vectors++;
    if (done_at !== 16) begin
      miscompares++;
      $display("FAIL resync_done got pixel %0d expected pixel 16", done_at);
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    vectors++;
    if ({bus.rd_valid, bus.rd_err, bus.rd_data} !== {2'b10, 16'hAA55}) begin
      miscompares++;
      $display("FAIL resync_read got v=%b e=%b d=%h expected v=1 e=0 d=aa55", bus.rd_valid, bus.rd_err, bus.rd_data);
    end
  endtask
  task automatic test_same_cycle();
    logic [15:0] first = 16'($urandom);
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, i == 0 ? first : 16'($urandom), 0, 0, 0, i == 11);
      step();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL same_cycle_px%0d got %h expected %h", i, obs, exp_v);
      end
    end
    vectors++;
    if ({bus.wr_ready, bus.rd_frame_avail, bus.wr_frame_done} !== 3'b111) begin
      miscompares++;
      $display("FAIL same_cycle_flags got %b expected 111", {bus.wr_ready, bus.rd_frame_avail, bus.wr_frame_done});
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    vectors++;
    if ({bus.rd_valid, bus.rd_err, bus.rd_data} !== {2'b10, first}) begin
      miscompares++;
      $display("FAIL same_cycle_read got d=%h e=%b expected d=%h e=0", bus.rd_data, bus.rd_err, first);
    end
  endtask
  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, i < 4, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 0);
      step();
      pulses += int'(bus.rd_valid);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d got %h expected %h", i, obs, exp_v);
      end
    end
    vectors++;
    if (pulses !== 4) begin
      miscompares++;
      $display("FAIL b2b_pulses got %0d expected 4", pulses);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 1, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    pulses = int'(bus.rd_valid);
    repeat (3) begin
      @(posedge clk);
      #1;
      pulses += int'(bus.rd_valid);
    end
    vectors++;
    if (pulses !== 0 || bus.rd_frame_avail !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midstream got pulses=%0d avail=%b expected pulses=0 avail=0", pulses, bus.rd_frame_avail);
    end
    rst_n = 1;
    model_clear();
  endtask
  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 16'($urandom),
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0);
      step();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random_cycle%0d got %h expected %h", i, obs, exp_v);
      end
    end
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    test_reset();
    test_single_frame();
    test_backpressure();
    test_errors();
    test_resync();
    test_same_cycle();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
